// File: rtl/io_pkg.sv
// Shared types and constants for the CPU-side I/O bus controller.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } io_state_t;

    localparam int          ADDR_W        = 16;
    localparam int          DATA_W        = 16;
    localparam int          IO_WINDOW_BIT = 15;
    localparam int          DEV_ID_W      = 11;
    localparam int          OFFSET_W      = 4;
    localparam logic [15:0] BUS_PULLUP    = 16'hFFFF;

    // The I/O window is the upper half of the word address space.
    function automatic logic in_io_window(input logic [ADDR_W-1:0] addr);
        return addr[IO_WINDOW_BIT];
    endfunction

    // Device ID sits between the window bit and the register offset.
    function automatic logic [DEV_ID_W-1:0] dev_id_of(input logic [ADDR_W-1:0] addr);
        return addr[IO_WINDOW_BIT-1:OFFSET_W];
    endfunction

    // Register offset within a device.
    function automatic logic [OFFSET_W-1:0] offset_of(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/io_addr_decoder.sv
// Maps a device ID inside the I/O window onto an attached slot.
// Lowest slot index wins when several slots share an ID, so the select stays one-hot.
module io_addr_decoder
    import io_pkg::*;
#(
    parameter int                  NUM_DEVICES = 4,
    parameter logic [DEV_ID_W-1:0] DEVICE_IDS [NUM_DEVICES] = '{11'd2047, 11'd2046, 11'd2045, 11'd2044},
    parameter int                  SLOT_W      = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
    input  logic                   window,
    input  logic [DEV_ID_W-1:0]    dev_id,
    output logic                   hit,
    output logic [SLOT_W-1:0]      slot,
    output logic [NUM_DEVICES-1:0] select
);

    // Priority search from slot 0 upward; first match claims the access.
    always_comb begin
        hit    = 1'b0;
        slot   = '0;
        select = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (!hit && window && (dev_id == DEVICE_IDS[i])) begin
                hit       = 1'b1;
                slot      = SLOT_W'(i);
                select[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_bus_controller.sv
// CPU-side I/O controller: one outstanding load/store to the I/O window,
// decoded onto a slot select, offset and shared read/write strobes.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | cpu_ready high; a pending cpu_req is latched and decoded
//  ACCESS | strobes and select driven; waiting for dev_ready or timeout
//  RESP   | one-cycle cpu_ack (with bus_error on failed accesses)
module io_bus_controller
    import io_pkg::*;
#(
    parameter int                  NUM_DEVICES    = 4,
    parameter logic [DEV_ID_W-1:0] DEVICE_IDS [NUM_DEVICES] = '{11'd2047, 11'd2046, 11'd2045, 11'd2044},
    parameter int                  TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic                          cpu_ready,
    output logic                          cpu_ack,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          bus_error,
    output logic [NUM_DEVICES-1:0]        device_select,
    output logic [OFFSET_W-1:0]           register_offset,
    output logic                          read_req,
    output logic                          write_req,
    output logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W*NUM_DEVICES-1:0] dev_rdata,
    input  logic [NUM_DEVICES-1:0]        dev_ready
);

    localparam int SLOT_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    io_state_t                state;
    logic                     we_q;
    logic [SLOT_W-1:0]        slot_q;
    logic [CNT_W-1:0]         wait_cnt;

    logic                     dec_hit;
    logic [SLOT_W-1:0]        dec_slot;
    logic [NUM_DEVICES-1:0]   dec_select;

    logic [DATA_W-1:0]        slot_rdata;
    logic                     slot_ready;

    io_addr_decoder #(
        .NUM_DEVICES (NUM_DEVICES),
        .DEVICE_IDS  (DEVICE_IDS),
        .SLOT_W      (SLOT_W)
    ) u_decoder (
        .window (in_io_window(cpu_addr)),
        .dev_id (dev_id_of(cpu_addr)),
        .hit    (dec_hit),
        .slot   (dec_slot),
        .select (dec_select)
    );

    // Pick the read data and ready of the slot owning the current access.
    always_comb begin
        slot_rdata = '0;
        slot_ready = 1'b0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                slot_rdata = dev_rdata[i*DATA_W +: DATA_W];
                slot_ready = dev_ready[i];
            end
        end
    end

    // Transaction FSM with registered CPU-side and device-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cpu_ready       <= 1'b1;
            cpu_ack         <= 1'b0;
            bus_error       <= 1'b0;
            cpu_rdata       <= '0;
            device_select   <= '0;
            register_offset <= '0;
            read_req        <= 1'b0;
            write_req       <= 1'b0;
            wdata           <= '0;
            we_q            <= 1'b0;
            slot_q          <= '0;
            wait_cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        cpu_ready       <= 1'b0;
                        we_q            <= cpu_we;
                        register_offset <= offset_of(cpu_addr);
                        wdata           <= cpu_wdata;
                        if (dec_hit) begin
                            // Mapped: drive the slot until it reports ready.
                            state         <= ACCESS;
                            slot_q        <= dec_slot;
                            device_select <= dec_select;
                            read_req      <= ~cpu_we;
                            write_req     <= cpu_we;
                            wait_cnt      <= '0;
                        end else begin
                            // Unmapped or outside the window: fail without touching the bus.
                            state     <= RESP;
                            cpu_ack   <= 1'b1;
                            bus_error <= 1'b1;
                            if (!cpu_we) begin
                                cpu_rdata <= BUS_PULLUP;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (slot_ready) begin
                        state         <= RESP;
                        cpu_ack       <= 1'b1;
                        device_select <= '0;
                        read_req      <= 1'b0;
                        write_req     <= 1'b0;
                        if (!we_q) begin
                            cpu_rdata <= slot_rdata;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        // Device never answered: release the bus and report an error.
                        state         <= RESP;
                        cpu_ack       <= 1'b1;
                        bus_error     <= 1'b1;
                        device_select <= '0;
                        read_req      <= 1'b0;
                        write_req     <= 1'b0;
                        if (!we_q) begin
                            cpu_rdata <= BUS_PULLUP;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    state     <= IDLE;
                    cpu_ack   <= 1'b0;
                    bus_error <= 1'b0;
                    cpu_ready <= 1'b1;
                end

                default: begin
                    state         <= IDLE;
                    cpu_ack       <= 1'b0;
                    bus_error     <= 1'b0;
                    cpu_ready     <= 1'b1;
                    device_select <= '0;
                    read_req      <= 1'b0;
                    write_req     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller.
module tb_io_bus_controller;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        bus_error;
    logic [3:0]  device_select;
    logic [3:0]  register_offset;
    logic        read_req;
    logic        write_req;
    logic [15:0] wdata;
    logic [63:0] dev_rdata;
    logic [3:0]  dev_ready;

    int checks_total;
    int checks_passed;

    io_bus_controller dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ready       (cpu_ready),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .bus_error       (bus_error),
        .device_select   (device_select),
        .register_offset (register_offset),
        .read_req        (read_req),
        .write_req       (write_req),
        .wdata           (wdata),
        .dev_rdata       (dev_rdata),
        .dev_ready       (dev_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        dev_ready = 4'b1111;
        dev_rdata = {16'h3333, 16'h2222, 16'h1111, 16'hA5A5};

        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_ready",  16'(cpu_ready),     16'h1);
        check("rst_ack",    16'(cpu_ack),       16'h0);
        check("rst_err",    16'(bus_error),     16'h0);
        check("rst_sel",    16'(device_select), 16'h0);
        check("rst_rd",     16'(read_req),      16'h0);
        check("rst_wr",     16'(write_req),     16'h0);
        check("rst_rdata",  cpu_rdata,          16'h0000);

        // Read 0xFFFE from slot 0
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFE;
        tick();
        cpu_req = 1'b0;
        check("rd0_sel",    16'(device_select),   16'h1);
        check("rd0_rd",     16'(read_req),        16'h1);
        check("rd0_wr",     16'(write_req),       16'h0);
        check("rd0_off",    16'(register_offset), 16'hE);
        check("rd0_noack",  16'(cpu_ack),         16'h0);
        check("rd0_busy",   16'(cpu_ready),       16'h0);
        tick();
        check("rd0_ack",    16'(cpu_ack),         16'h1);
        check("rd0_data",   cpu_rdata,            16'hA5A5);
        check("rd0_err",    16'(bus_error),       16'h0);
        check("rd0_rddrop", 16'(read_req),        16'h0);
        check("rd0_seldrp", 16'(device_select),   16'h0);
        tick();
        check("rd0_ackend", 16'(cpu_ack),         16'h0);
        check("rd0_idle",   16'(cpu_ready),       16'h1);
        check("rd0_hold",   cpu_rdata,            16'hA5A5);

        // Write 0xFFFF data 0x00FF
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFFFF; cpu_wdata = 16'h00FF;
        tick();
        cpu_req = 1'b0;
        check("wr_wr",      16'(write_req),       16'h1);
        check("wr_rd",      16'(read_req),        16'h0);
        check("wr_off",     16'(register_offset), 16'hF);
        check("wr_wdata",   wdata,                16'h00FF);
        check("wr_sel",     16'(device_select),   16'h1);
        tick();
        check("wr_ack",     16'(cpu_ack),         16'h1);
        check("wr_err",     16'(bus_error),       16'h0);
        check("wr_wrdrop",  16'(write_req),       16'h0);
        check("wr_rdata",   cpu_rdata,            16'hA5A5);
        tick();

        // Read 0x1234: outside the I/O window
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
        tick();
        cpu_req = 1'b0;
        check("low_ack",    16'(cpu_ack),         16'h1);
        check("low_err",    16'(bus_error),       16'h1);
        check("low_data",   cpu_rdata,            16'hFFFF);
        check("low_rd",     16'(read_req),        16'h0);
        check("low_sel",    16'(device_select),   16'h0);
        tick();
        check("low_ackend", 16'(cpu_ack),         16'h0);
        check("low_errend", 16'(bus_error),       16'h0);
        check("low_idle",   16'(cpu_ready),       16'h1);

        // Read 0xFFD3 from slot 2 (ID 2045)
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFD3;
        tick();
        cpu_req = 1'b0;
        check("rd2_sel",    16'(device_select),   16'h4);
        check("rd2_off",    16'(register_offset), 16'h3);
        tick();
        check("rd2_ack",    16'(cpu_ack),         16'h1);
        check("rd2_data",   cpu_rdata,            16'h2222);
        tick();

        // Read 0x8010: ID 1, no slot
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8010;
        tick();
        cpu_req = 1'b0;
        check("unm_ack",    16'(cpu_ack),         16'h1);
        check("unm_err",    16'(bus_error),       16'h1);
        check("unm_data",   cpu_rdata,            16'hFFFF);
        check("unm_rd",     16'(read_req),        16'h0);
        tick();

        // Slot 1 holds ready low for 5 ACCESS cycles
        dev_ready[1] = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFE0;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("wait_rd",    16'(read_req),      16'h1);
            check("wait_sel",   16'(device_select), 16'h2);
            check("wait_noack", 16'(cpu_ack),       16'h0);
            tick();
        end
        dev_ready[1] = 1'b1;
        check("wait_rd6",   16'(read_req),        16'h1);
        tick();
        check("wait_ack",   16'(cpu_ack),         16'h1);
        check("wait_data",  cpu_rdata,            16'h1111);
        check("wait_err",   16'(bus_error),       16'h0);
        check("wait_rdend", 16'(read_req),        16'h0);
        tick();

        // Slot 1 never ready: timeout after 16 ACCESS cycles
        dev_ready[1] = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFE0;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("to_rd",    16'(read_req), 16'h1);
            check("to_noack", 16'(cpu_ack),  16'h0);
            tick();
        end
        check("to_ack",     16'(cpu_ack),         16'h1);
        check("to_err",     16'(bus_error),       16'h1);
        check("to_data",    cpu_rdata,            16'hFFFF);
        check("to_rddrop",  16'(read_req),        16'h0);
        check("to_seldrop", 16'(device_select),   16'h0);
        tick();
        check("to_errend",  16'(bus_error),       16'h0);
        dev_ready[1] = 1'b1;

        // Back-to-back: cpu_req stays high across three requests
        begin
            logic [15:0] addrs [3];
            logic [15:0] datas [3];
            addrs = '{16'hFFFE, 16'hFFD0, 16'hFFC0};
            datas = '{16'hA5A5, 16'h2222, 16'h3333};
            cpu_req = 1'b1; cpu_we = 1'b0;
            for (int j = 0; j < 3; j++) begin
                cpu_addr = addrs[j];
                check("b2b_accept", 16'(cpu_ready), 16'h1);
                tick();
                check("b2b_access", 16'(read_req),  16'h1);
                check("b2b_noack",  16'(cpu_ack),   16'h0);
                check("b2b_busy",   16'(cpu_ready), 16'h0);
                tick();
                check("b2b_ack",    16'(cpu_ack),   16'h1);
                check("b2b_data",   cpu_rdata,      datas[j]);
                check("b2b_rbusy",  16'(cpu_ready), 16'h0);
                tick();
            end
            cpu_req = 1'b0;
            check("b2b_ackend", 16'(cpu_ack), 16'h0);
            tick();
        end

        // Reset during an ACCESS wait
        dev_ready[1] = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFE0;
        tick();
        cpu_req = 1'b0;
        tick();
        check("rw_rd",      16'(read_req),        16'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_ready",   16'(cpu_ready),       16'h1);
        check("rw_rd0",     16'(read_req),        16'h0);
        check("rw_sel0",    16'(device_select),   16'h0);
        check("rw_ack0",    16'(cpu_ack),         16'h0);
        check("rw_err0",    16'(bus_error),       16'h0);
        tick();
        check("rw_noack",   16'(cpu_ack),         16'h0);
        check("rw_idle",    16'(cpu_ready),       16'h1);
        dev_ready[1] = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFE0;
        tick();
        cpu_req = 1'b0;
        check("rw2_sel",    16'(device_select),   16'h2);
        tick();
        check("rw2_ack",    16'(cpu_ack),         16'h1);
        check("rw2_data",   cpu_rdata,            16'h1111);
        check("rw2_err",    16'(bus_error),       16'h0);
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
